rgb_led_array_driver: RTL

Parametrised driver for the game's RGB LED row, and the successor to the fixed 4-LED guess/history driver. It generalises LED count, colour width and blink period. It adds an OFF mode, a WIN mode where all LEDs flash in unison, and global PWM brightness dimming. It sits between the game controller (mode, cursor, colour vectors) and the board RGB pins; all outputs are registered.

---
 rtl/rgb_led_array_driver_if.sv | 27 ++
 rtl/rgb_led_array_driver.sv | 90 +++++++++
 2 files changed

// File: rtl/rgb_led_array_driver_if.sv
// Controller-to-driver bundle for the RGB LED row: mode, cursor, brightness
// and colour vectors flow towards the driver, registered pin drive and
// blink phase flow back.
interface rgb_led_array_driver_if #(
    parameter int NUM_LEDS = 4,
    parameter int COLOR_W  = 3,
    parameter int PWM_W    = 4,
    parameter int CUR_W    = 2
);
    logic [1:0]                  mode;
    logic [CUR_W-1:0]            cursor;
    logic [PWM_W-1:0]            brightness;
    logic [NUM_LEDS*COLOR_W-1:0] guess_rgb;
    logic [NUM_LEDS*COLOR_W-1:0] history_rgb;
    logic [NUM_LEDS*COLOR_W-1:0] rgb_out;
    logic                        blink_phase;

    modport master (
        output mode, cursor, brightness, guess_rgb, history_rgb,
        input  rgb_out, blink_phase
    );

    modport slave (
        input  mode, cursor, brightness, guess_rgb, history_rgb,
        output rgb_out, blink_phase
    );
endinterface

// File: rtl/rgb_led_array_driver.sv
// Parametrised RGB LED row driver with OFF / HISTORY / GUESS / WIN modes,
// cursor blink, unison win flash and global PWM brightness dimming.
// Every output is registered; nothing combinational reaches the pins.
module rgb_led_array_driver #(
    parameter int NUM_LEDS  = 4,
    parameter int COLOR_W   = 3,
    parameter int BLINK_DIV = 25000000,
    parameter int PWM_W     = 4,
    parameter int CUR_W     = 2
) (
    input logic                  clk,
    input logic                  rst,
    rgb_led_array_driver_if.slave bus
);
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int RGB_W = NUM_LEDS * COLOR_W;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_HISTORY = 2'd1,
        MODE_GUESS   = 2'd2,
        MODE_WIN     = 2'd3
    } mode_t;

    logic [CNT_W-1:0]   blink_cnt;
    logic               blink_phase_q;
    logic [PWM_W-1:0]   pwm_cnt;
    logic [1:0]         mode_q;
    logic [CUR_W-1:0]   cursor_q;
    logic [RGB_W-1:0]   rgb_q;
    logic [RGB_W-1:0]   rgb_next;
    logic [COLOR_W-1:0] colour;
    logic               pwm_on;
    logic               restart;
    mode_t              mode_in;

    assign mode_in         = mode_t'(bus.mode);
    assign restart         = (bus.mode != mode_q) || (bus.cursor != cursor_q);
    assign bus.rgb_out     = rgb_q;
    assign bus.blink_phase = blink_phase_q;

    // Per-LED colour selection for the next edge, gated by the PWM duty
    always_comb begin
        pwm_on   = (bus.brightness == {PWM_W{1'b1}}) || (pwm_cnt < bus.brightness);
        rgb_next = '0;
        colour   = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            colour = '0;
            case (mode_in)
                MODE_OFF:     colour = '0;
                MODE_HISTORY: colour = bus.history_rgb[i*COLOR_W +: COLOR_W];
                MODE_GUESS: begin
                    if (!blink_phase_q && (int'(bus.cursor) == i))
                        colour = '0;
                    else
                        colour = bus.guess_rgb[i*COLOR_W +: COLOR_W];
                end
                MODE_WIN:     colour = blink_phase_q ? bus.guess_rgb[i*COLOR_W +: COLOR_W] : '0;
                default:      colour = '0;
            endcase
            rgb_next[i*COLOR_W +: COLOR_W] = colour & {COLOR_W{pwm_on}};
        end
    end

    // Blink timer with restart on mode/cursor change, PWM counter and pin register
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q         <= '0;
            blink_phase_q <= 1'b1;
            blink_cnt     <= '0;
            pwm_cnt       <= '0;
            mode_q        <= '0;
            cursor_q      <= '0;
        end else begin
            mode_q   <= bus.mode;
            cursor_q <= bus.cursor;
            pwm_cnt  <= pwm_cnt + PWM_W'(1);
            rgb_q    <= rgb_next;
            if (restart) begin
                blink_cnt     <= '0;
                blink_phase_q <= 1'b1;
            end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
                blink_cnt     <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end
        end
    end
endmodule
